// File: rtl/clock_set_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_controller_if
// Purpose  : Panel inputs, time/alarm snapshots and edit/strobe outputs of
//            the clock mode/setting sequencer, bundled as one interface.
// Revision : 1.0  initial release
// ============================================================================
interface clock_set_controller_if;
   logic       mode_btn;
   logic       inc_btn;
   logic       alarm_sw;
   logic       sec_tick;
   logic [4:0] cur_hour;
   logic [5:0] cur_min;
   logic [4:0] alm_hour;
   logic [5:0] alm_min;
   logic [2:0] state;
   logic [4:0] edit_hour;
   logic [5:0] edit_min;
   logic       time_load;
   logic       alarm_load;
   logic       alarm_armed;
   logic       blink;

   // Sequencer side
   modport slave (
      input  mode_btn, inc_btn, alarm_sw, sec_tick,
      input  cur_hour, cur_min, alm_hour, alm_min,
      output state, edit_hour, edit_min, time_load, alarm_load, alarm_armed, blink
   );

   // Panel / timekeeping side
   modport master (
      output mode_btn, inc_btn, alarm_sw, sec_tick,
      output cur_hour, cur_min, alm_hour, alm_min,
      input  state, edit_hour, edit_min, time_load, alarm_load, alarm_armed, blink
   );
endinterface
`default_nettype wire

// File: rtl/clock_set_controller.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_controller
// Purpose  : Mode/setting sequencer for the alarm clock: debounces buttons,
//            auto-repeats increment, edits time and alarm, issues load
//            strobes and aborts an edit after an inactivity timeout.
// Revision : 1.0  initial release
// ============================================================================
module clock_set_controller #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLD_CYCLES     = 64,
   parameter int REPEAT_CYCLES   = 16,
   parameter int TIMEOUT_TICKS   = 30
) (
   input  wire logic               clk,
   input  wire logic               reset,
   clock_set_controller_if.slave   bus
);

   localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int c_HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int c_REP_W  = $clog2(REPEAT_CYCLES + 1);
   localparam int c_IDLE_W = $clog2(TIMEOUT_TICKS + 1);

   localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_FULL = c_HOLD_W'(HOLD_CYCLES);
   localparam logic [c_HOLD_W-1:0] c_HOLD_PRE  = c_HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [c_REP_W-1:0]  c_REP_LAST  = c_REP_W'(REPEAT_CYCLES - 1);
   localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_TICKS - 1);

   localparam logic [2:0] c_ST_RUN      = 3'd0;
   localparam logic [2:0] c_ST_SET_HR   = 3'd1;
   localparam logic [2:0] c_ST_SET_MIN  = 3'd2;
   localparam logic [2:0] c_ST_SET_AHR  = 3'd3;
   localparam logic [2:0] c_ST_SET_AMIN = 3'd4;

   // bit 0 = mode button, bit 1 = increment button
   wire [1:0] w_raw;
   wire [1:0] w_db;
   wire [1:0] w_ev;
   assign w_raw = {bus.inc_btn, bus.mode_btn};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_db
         logic [c_DB_W-1:0] r_cnt;
         logic              r_lvl;
         logic              r_lvl_d;
         logic              r_pulse;

         // Debounce: level flips after DEBOUNCE_CYCLES differing samples; press pulse one cycle later
         always_ff @(posedge clk) begin
            if (reset) begin
               r_cnt   <= '0;
               r_lvl   <= 1'b0;
               r_lvl_d <= 1'b0;
               r_pulse <= 1'b0;
            end else begin
               r_lvl_d <= r_lvl;
               r_pulse <= r_lvl & ~r_lvl_d;
               if (w_raw[gi] == r_lvl) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_DB_LAST) begin
                  r_lvl <= w_raw[gi];
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + c_DB_W'(1);
               end
            end
         end

         assign w_db[gi] = r_lvl;
         assign w_ev[gi] = r_pulse;
      end
   endgenerate

   logic [c_HOLD_W-1:0] r_hold;
   logic [c_REP_W-1:0]  r_rcnt;
   logic                r_rep;

   // Auto-repeat: first extra inc HOLD_CYCLES after the press event, then every REPEAT_CYCLES
   always_ff @(posedge clk) begin
      if (reset || !w_db[1]) begin
         r_hold <= '0;
         r_rcnt <= '0;
         r_rep  <= 1'b0;
      end else if (w_ev[1]) begin
         // Re-align so the count equals cycles elapsed since the press event
         r_hold <= c_HOLD_W'(1);
         r_rcnt <= '0;
         r_rep  <= 1'b0;
      end else if (r_hold != c_HOLD_FULL) begin
         r_hold <= r_hold + c_HOLD_W'(1);
         r_rep  <= (r_hold == c_HOLD_PRE);
      end else if (r_rcnt == c_REP_LAST) begin
         r_rcnt <= '0;
         r_rep  <= 1'b1;
      end else begin
         r_rcnt <= r_rcnt + c_REP_W'(1);
         r_rep  <= 1'b0;
      end
   end

   logic w_mode_ev;
   logic w_inc_ev;
   logic w_any_ev;
   assign w_mode_ev = w_ev[0];
   assign w_inc_ev  = w_ev[1] | r_rep;
   assign w_any_ev  = w_mode_ev | w_inc_ev;

   logic [2:0]          r_state;
   logic [2:0]          w_state_n;
   logic [c_IDLE_W-1:0] r_idle;
   logic                w_timeout;

   assign w_timeout = bus.sec_tick & ~w_any_ev & (r_state != c_ST_RUN) & (r_idle == c_IDLE_LAST);

   // Inactivity counter: seconds since the last press event while editing
   always_ff @(posedge clk) begin
      if (reset || r_state == c_ST_RUN || w_any_ev) begin
         r_idle <= '0;
      end else if (bus.sec_tick && r_idle != c_IDLE_LAST) begin
         r_idle <= r_idle + c_IDLE_W'(1);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= c_ST_RUN;
      else       r_state <= w_state_n;
   end

   // Next state: mode advances the sequence, timeout drops back to RUN
   always_comb begin
      w_state_n = r_state;
      if (w_mode_ev) begin
         case (r_state)
            c_ST_RUN:     w_state_n = c_ST_SET_HR;
            c_ST_SET_HR:  w_state_n = c_ST_SET_MIN;
            c_ST_SET_MIN: w_state_n = c_ST_SET_AHR;
            c_ST_SET_AHR: w_state_n = c_ST_SET_AMIN;
            default:      w_state_n = c_ST_RUN;
         endcase
      end else if (w_timeout) begin
         w_state_n = c_ST_RUN;
      end
   end

   logic [4:0] r_eh, w_eh_n;
   logic [5:0] r_em, w_em_n;
   logic       r_tl, w_tl_n;
   logic       r_al, w_al_n;

   // Outputs: edit register updates and load strobes; mode beats inc
   always_comb begin
      w_eh_n = r_eh;
      w_em_n = r_em;
      w_tl_n = 1'b0;
      w_al_n = 1'b0;
      if (r_tl) begin
         // Cycle after the time commit: pick up the stored alarm for editing
         w_eh_n = bus.alm_hour;
         w_em_n = bus.alm_min;
      end else begin
         case (r_state)
            c_ST_RUN: begin
               if (w_mode_ev) begin
                  w_eh_n = bus.cur_hour;
                  w_em_n = bus.cur_min;
               end
            end
            c_ST_SET_HR, c_ST_SET_AHR: begin
               if (!w_mode_ev && w_inc_ev) w_eh_n = (r_eh == 5'd23) ? 5'd0 : r_eh + 5'd1;
            end
            c_ST_SET_MIN: begin
               if (w_mode_ev)     w_tl_n = 1'b1;
               else if (w_inc_ev) w_em_n = (r_em == 6'd59) ? 6'd0 : r_em + 6'd1;
            end
            c_ST_SET_AMIN: begin
               if (w_mode_ev)     w_al_n = 1'b1;
               else if (w_inc_ev) w_em_n = (r_em == 6'd59) ? 6'd0 : r_em + 6'd1;
            end
            default: ;
         endcase
      end
   end

   logic r_blink;
   logic r_armed;

   // Edit registers, strobes, blink and alarm switch sampling
   always_ff @(posedge clk) begin
      if (reset) begin
         r_eh    <= 5'd0;
         r_em    <= 6'd0;
         r_tl    <= 1'b0;
         r_al    <= 1'b0;
         r_blink <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_eh    <= w_eh_n;
         r_em    <= w_em_n;
         r_tl    <= w_tl_n;
         r_al    <= w_al_n;
         r_armed <= bus.alarm_sw;
         if (r_state == c_ST_RUN) r_blink <= 1'b0;
         else if (bus.sec_tick)   r_blink <= ~r_blink;
      end
   end

   assign bus.state       = r_state;
   assign bus.edit_hour   = r_eh;
   assign bus.edit_min    = r_em;
   assign bus.time_load   = r_tl;
   assign bus.alarm_load  = r_al;
   assign bus.blink       = r_blink & (r_state != c_ST_RUN);
   assign bus.alarm_armed = r_armed & (r_state == c_ST_RUN);

endmodule
`default_nettype wire
